// File: rtl/encrypt_ctrl.sv
// encrypt_ctrl
// Sequencer for the LWE encrypt datapath. Accepts one job (plaintext plus
// noise/row-select vector) on a valid/ready handshake, then walks rows
// 0..DIMENSION. For each row it reads the public-key row, lets the datapath
// compute and streams the captured ciphertext word out with backpressure.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   job_valid/ready   job handshake; job_plaintext, job_noise are the payload
//   pk_rd_en, pk_addr key-memory read strobe and row address (1-cycle latency)
//   enc_plaintext     datapath plaintext, held for the whole job
//   enc_noise_select  datapath noise/row-select vector, held for the whole job
//   enc_row           current row index, zero-extended
//   enc_ciphertext    datapath result, captured at the end of COMPUTE
//   ct_valid/ready    ciphertext output handshake
//   ct_data, ct_index ciphertext word and its row index
//   ct_last           word belongs to row DIMENSION
//   busy              a job is in flight
//   done              one-cycle pulse after the final word handshakes
module encrypt_ctrl #(
    parameter int PLAINTEXT_WIDTH  = 6,
    parameter int CIPHERTEXT_WIDTH = 10,
    parameter int DIMENSION        = 10,
    parameter int BIG_N            = 30,
    parameter int ROW_ADDR_WIDTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        job_valid,
    output logic                        job_ready,
    input  logic [PLAINTEXT_WIDTH-1:0]  job_plaintext,
    input  logic [BIG_N-1:0]            job_noise,
    output logic                        pk_rd_en,
    output logic [ROW_ADDR_WIDTH-1:0]   pk_addr,
    output logic [PLAINTEXT_WIDTH-1:0]  enc_plaintext,
    output logic [BIG_N-1:0]            enc_noise_select,
    output logic [DIMENSION:0]          enc_row,
    input  logic [CIPHERTEXT_WIDTH-1:0] enc_ciphertext,
    output logic                        ct_valid,
    input  logic                        ct_ready,
    output logic [CIPHERTEXT_WIDTH-1:0] ct_data,
    output logic [ROW_ADDR_WIDTH-1:0]   ct_index,
    output logic                        ct_last,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        COMPUTE = 2'd2,
        EMIT    = 2'd3
    } state_t;

    localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW = ROW_ADDR_WIDTH'(DIMENSION);

    state_t                        state_reg, state_next;
    logic [PLAINTEXT_WIDTH-1:0]    plaintext_reg, plaintext_next;
    logic [BIG_N-1:0]              noise_reg, noise_next;
    logic [ROW_ADDR_WIDTH-1:0]     row_reg, row_next;
    logic [CIPHERTEXT_WIDTH-1:0]   ct_data_reg, ct_data_next;
    logic [ROW_ADDR_WIDTH-1:0]     ct_index_reg, ct_index_next;
    logic                          ct_last_reg, ct_last_next;
    logic                          ct_valid_reg, ct_valid_next;
    logic                          done_reg, done_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            plaintext_reg <= '0;
            noise_reg     <= '0;
            row_reg       <= '0;
            ct_data_reg   <= '0;
            ct_index_reg  <= '0;
            ct_last_reg   <= 1'b0;
            ct_valid_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            plaintext_reg <= plaintext_next;
            noise_reg     <= noise_next;
            row_reg       <= row_next;
            ct_data_reg   <= ct_data_next;
            ct_index_reg  <= ct_index_next;
            ct_last_reg   <= ct_last_next;
            ct_valid_reg  <= ct_valid_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        plaintext_next = plaintext_reg;
        noise_next     = noise_reg;
        row_next       = row_reg;
        ct_data_next   = ct_data_reg;
        ct_index_next  = ct_index_reg;
        ct_last_next   = ct_last_reg;
        ct_valid_next  = ct_valid_reg;
        done_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (job_valid && job_ready) begin
                    plaintext_next = job_plaintext;
                    noise_next     = job_noise;
                    row_next       = '0;
                    state_next     = FETCH;
                end
            end
            FETCH: begin
                state_next = COMPUTE;
            end
            COMPUTE: begin
                // Key-memory data arrived this cycle, so the datapath result
                // is valid now and is captured at this edge.
                ct_data_next  = enc_ciphertext;
                ct_index_next = row_reg;
                ct_last_next  = (row_reg == LAST_ROW);
                ct_valid_next = 1'b1;
                state_next    = EMIT;
            end
            EMIT: begin
                if (ct_ready) begin
                    ct_valid_next = 1'b0;
                    if (row_reg == LAST_ROW) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        row_next   = row_reg + ROW_ADDR_WIDTH'(1);
                        state_next = FETCH;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The IDLE-return cycle (done high) still refuses a new job.
    assign job_ready        = (state_reg == IDLE) && !done_reg;
    assign busy             = (state_reg != IDLE);
    assign done             = done_reg;
    assign pk_rd_en         = (state_reg == FETCH);
    assign pk_addr          = row_reg;
    assign enc_plaintext    = plaintext_reg;
    assign enc_noise_select = noise_reg;
    assign ct_valid         = ct_valid_reg;
    assign ct_data          = ct_data_reg;
    assign ct_index         = ct_index_reg;
    assign ct_last          = ct_last_reg;

    // Zero-extend the row index onto the datapath row bus.
    generate
        for (genvar gi = 0; gi <= DIMENSION; gi++) begin : g_enc_row
            if (gi < ROW_ADDR_WIDTH) begin : g_bit
                assign enc_row[gi] = row_reg[gi];
            end else begin : g_zero
                assign enc_row[gi] = 1'b0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_encrypt_ctrl.sv
// Testbench for encrypt_ctrl: behavioural key memory and datapath around the
// controller, table-driven job vectors, hand-written corner sequences and
// randomized jobs checked against a reference model.
module tb_encrypt_ctrl;

    localparam int PW = 6;
    localparam int CW = 10;
    localparam int D  = 10;
    localparam int N  = 30;
    localparam int AW = 4;

    logic          clk;
    logic          rst_n;
    logic          job_valid;
    logic          job_ready;
    logic [PW-1:0] job_plaintext;
    logic [N-1:0]  job_noise;
    logic          pk_rd_en;
    logic [AW-1:0] pk_addr;
    logic [PW-1:0] enc_plaintext;
    logic [N-1:0]  enc_noise_select;
    logic [D:0]    enc_row;
    logic [CW-1:0] enc_ciphertext;
    logic          ct_valid;
    logic          ct_ready;
    logic [CW-1:0] ct_data;
    logic [AW-1:0] ct_index;
    logic          ct_last;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;

    encrypt_ctrl #(
        .PLAINTEXT_WIDTH(PW), .CIPHERTEXT_WIDTH(CW), .DIMENSION(D),
        .BIG_N(N), .ROW_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_plaintext(job_plaintext), .job_noise(job_noise),
        .pk_rd_en(pk_rd_en), .pk_addr(pk_addr),
        .enc_plaintext(enc_plaintext), .enc_noise_select(enc_noise_select),
        .enc_row(enc_row), .enc_ciphertext(enc_ciphertext),
        .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
        .ct_index(ct_index), .ct_last(ct_last), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key memory: 16 rows of N samples, synchronous 1-cycle read.
    logic [CW-1:0] key_mem [0:15][0:N-1];
    logic [CW-1:0] pk_data [0:N-1];

    always @(posedge clk) begin
        if (pk_rd_en) begin
            for (int j = 0; j < N; j++) pk_data[j] <= key_mem[pk_addr][j];
        end
    end

    // Datapath: selected samples summed, plaintext injected on row 1.
    int dp_sum;
    always_comb begin
        dp_sum = 0;
        for (int j = 0; j < N; j++) begin
            if (enc_noise_select[j]) dp_sum = dp_sum + int'(pk_data[j]);
        end
        if (enc_row == (D+1)'(1)) dp_sum = dp_sum + int'(enc_plaintext);
        enc_ciphertext = CW'(dp_sum);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_keys(input int kind);
        for (int r = 0; r < 16; r++) begin
            for (int j = 0; j < N; j++) begin
                case (kind)
                    0:       key_mem[r][j] = CW'(r + 1);
                    1:       key_mem[r][j] = 10'd1023;
                    default: key_mem[r][j] = CW'($urandom_range(0, 1023));
                endcase
            end
        end
    endtask

    // Reference: word r = (sum of selected row-r samples + [r==1]*pt) mod 2^CW.
    function automatic logic [D:0][CW-1:0] ref_words(input logic [PW-1:0] pt, input logic [N-1:0] nz);
        logic [D:0][CW-1:0] w;
        for (int r = 0; r <= D; r++) begin
            int s;
            s = 0;
            for (int j = 0; j < N; j++) if (nz[j]) s += int'(key_mem[r][j]);
            if (r == 1) s += int'(pt);
            w[r] = CW'(s % 1024);
        end
        return w;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_job_ready"}, 32'(job_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ct_valid"}, 32'(ct_valid), 32'd0);
        check({tag, "_ct_data"}, 32'(ct_data), 32'd0);
        check({tag, "_ct_index"}, 32'(ct_index), 32'd0);
        check({tag, "_ct_last"}, 32'(ct_last), 32'd0);
        check({tag, "_pk_rd_en"}, 32'(pk_rd_en), 32'd0);
        check({tag, "_pk_addr"}, 32'(pk_addr), 32'd0);
        check({tag, "_enc_pt"}, 32'(enc_plaintext), 32'd0);
        check({tag, "_enc_noise"}, 32'(enc_noise_select), 32'd0);
        check({tag, "_enc_row"}, 32'(enc_row), 32'd0);
    endtask

    // Offers one job and follows it to done. mode: 0 ready always high,
    // 1 seven-cycle stall on row 3, 2 random ready. exp_done < 0 skips the
    // cycle-count check. hold keeps job_valid high with a second payload.
    task automatic run_job(input string tag, input logic [PW-1:0] pt, input logic [N-1:0] nz,
                           input int mode, input logic [D:0][CW-1:0] exp_w, input int exp_done,
                           input bit hold, input logic [PW-1:0] pt2, input logic [N-1:0] nz2);
        int nwords, last_hs, stall;
        bit prev_hs, prev_stall, prev_last, finished;
        logic [CW-1:0] prev_data;
        logic [AW-1:0] prev_idx;
        @(negedge clk);
        check({tag, "_job_ready_idle"}, 32'(job_ready), 32'd1);
        job_valid = 1'b1; job_plaintext = pt; job_noise = nz; ct_ready = 1'b0;
        @(posedge clk); #1;
        if (hold) begin
            job_plaintext = pt2; job_noise = nz2;
        end else begin
            job_valid = 1'b0;
        end
        nwords = 0; last_hs = -1; stall = 0;
        prev_hs = 0; prev_stall = 0; prev_last = 0; finished = 0;
        prev_data = '0; prev_idx = '0;
        for (int k = 0; k < 3000 && !finished; k++) begin
            @(negedge clk);
            if (done) begin
                check({tag, "_done_after_last"}, 32'(k), 32'(last_hs + 1));
                check({tag, "_word_count"}, 32'(nwords), 32'(D + 1));
                if (exp_done >= 0) check({tag, "_done_cycle"}, 32'(k), 32'(exp_done));
                check({tag, "_ready_in_done"}, 32'(job_ready), 32'd0);
                check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
                check({tag, "_valid_in_done"}, 32'(ct_valid), 32'd0);
                finished = 1;
            end else begin
                check({tag, "_busy"}, 32'(busy), 32'd1);
                check({tag, "_ready_busy"}, 32'(job_ready), 32'd0);
                if (k == 0) begin
                    check({tag, "_first_fetch"}, 32'(pk_rd_en), 32'd1);
                    check({tag, "_first_addr"}, 32'(pk_addr), 32'd0);
                end
                if (prev_stall) begin
                    check({tag, "_hold_valid"}, 32'(ct_valid), 32'd1);
                    check({tag, "_hold_data"}, 32'(ct_data), 32'(prev_data));
                    check({tag, "_hold_index"}, 32'(ct_index), 32'(prev_idx));
                end
                if (prev_hs && !prev_last) begin
                    check({tag, "_next_fetch"}, 32'(pk_rd_en), 32'd1);
                    check({tag, "_next_addr"}, 32'(pk_addr), 32'(AW'(prev_idx + 1)));
                end
                if (ct_valid) check({tag, "_no_read_in_emit"}, 32'(pk_rd_en), 32'd0);
                case (mode)
                    0: ct_ready = 1'b1;
                    1: begin
                        if (ct_valid && ct_index == AW'(3) && stall < 7) begin
                            ct_ready = 1'b0; stall++;
                        end else begin
                            ct_ready = 1'b1;
                        end
                    end
                    default: ct_ready = 1'($urandom_range(0, 1));
                endcase
                prev_hs    = ct_valid && ct_ready;
                prev_stall = ct_valid && !ct_ready;
                prev_data  = ct_data;
                prev_idx   = ct_index;
                prev_last  = ct_last;
                if (prev_hs) begin
                    check({tag, "_index"}, 32'(ct_index), 32'(nwords));
                    if (nwords <= D) check({tag, "_data"}, 32'(ct_data), 32'(exp_w[nwords]));
                    check({tag, "_last"}, 32'(ct_last), 32'(nwords == D));
                    $display("%s word idx=%0d data=%0d last=%0d", tag, ct_index, ct_data, ct_last);
                    last_hs = k;
                    nwords++;
                end
            end
        end
        if (!finished) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    typedef struct {
        int                 key_kind;
        logic [PW-1:0]      pt;
        logic [N-1:0]       noise;
        int                 ready_mode;
        int                 exp_done;
        logic [D:0][CW-1:0] exp_w;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [PW-1:0]      pa, pb;
        logic [N-1:0]       na, nb;
        logic [D:0][CW-1:0] wa, wb;
        bit                 found;

        // Expected words written from the stated arithmetic of each case.
        vecs[0].key_kind = 0; vecs[0].pt = 6'd5;  vecs[0].noise = 30'h1;
        vecs[0].ready_mode = 0; vecs[0].exp_done = 33;
        vecs[1].key_kind = 1; vecs[1].pt = 6'd0;  vecs[1].noise = 30'h3FFF_FFFF;
        vecs[1].ready_mode = 0; vecs[1].exp_done = 33;
        vecs[2].key_kind = 0; vecs[2].pt = 6'd5;  vecs[2].noise = 30'h1;
        vecs[2].ready_mode = 1; vecs[2].exp_done = 40;
        vecs[3].key_kind = 0; vecs[3].pt = 6'd63; vecs[3].noise = 30'h0;
        vecs[3].ready_mode = 0; vecs[3].exp_done = 33;
        for (int r = 0; r <= D; r++) begin
            vecs[0].exp_w[r] = CW'(r + 1);
            vecs[1].exp_w[r] = 10'd994;
            vecs[2].exp_w[r] = CW'(r + 1);
            vecs[3].exp_w[r] = 10'd0;
        end
        vecs[0].exp_w[1] = 10'd7;
        vecs[2].exp_w[1] = 10'd7;
        vecs[3].exp_w[1] = 10'd63;

        rst_n = 1'b0; job_valid = 1'b0; job_plaintext = '0; job_noise = '0; ct_ready = 1'b0;
        load_keys(0);
        #2;
        check_reset_outputs("por");
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            load_keys(vecs[i].key_kind);
            run_job($sformatf("vec%0d", i), vecs[i].pt, vecs[i].noise, vecs[i].ready_mode,
                    vecs[i].exp_w, vecs[i].exp_done, 1'b0, '0, '0);
        end

        // job_valid held through a job with a second payload waiting behind it.
        load_keys(2);
        pa = PW'($urandom); na = N'($urandom);
        pb = PW'($urandom); nb = N'($urandom);
        wa = ref_words(pa, na);
        wb = ref_words(pb, nb);
        run_job("holdA", pa, na, 0, wa, 33, 1'b1, pb, nb);
        run_job("holdB", pb, nb, 0, wb, 33, 1'b0, '0, '0);

        // Reset in the middle of row 5's EMIT, stalled.
        load_keys(0);
        @(negedge clk);
        job_valid = 1'b1; job_plaintext = 6'd5; job_noise = 30'h1; ct_ready = 1'b1;
        @(posedge clk); #1;
        job_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (ct_valid && ct_index == AW'(5)) begin
                ct_ready = 1'b0;
                found = 1;
            end
        end
        check("rst_reach_row5", 32'(found), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk); rst_n = 1'b1;
        #1;
        check("rst_release_ready", 32'(job_ready), 32'd1);
        run_job("after_rst", vecs[0].pt, vecs[0].noise, 0, vecs[0].exp_w, 33, 1'b0, '0, '0);

        // Randomized jobs against the reference model.
        for (int t = 0; t < 6; t++) begin
            load_keys(2);
            pa = PW'($urandom); na = N'($urandom);
            if (t == 0) na = '1;
            wa = ref_words(pa, na);
            run_job($sformatf("rand%0d", t), pa, na, (t == 1) ? 0 : 2, wa,
                    (t == 1) ? 33 : -1, 1'b0, '0, '0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/encrypt_ctrl.md
Name: encrypt_ctrl

Overview:
Sequencer for the LWE `encrypt` datapath. It accepts one encryption job (a plaintext plus a BIG_N-bit noise/row-select vector) over a valid/ready handshake. It then walks row index 0..DIMENSION: for each row it reads that public-key row from the key memory, drives the datapath, captures the resulting ciphertext word and streams it out with backpressure. It sits between the job source (plaintext/RNG front-end) and the ciphertext output buffer.

Parameters:
- PLAINTEXT_WIDTH, 6, plaintext bits.
- CIPHERTEXT_WIDTH, 10, ciphertext word bits.
- DIMENSION, 10, LWE dimension; each job produces DIMENSION+1 words.
- BIG_N, 30, number of public-key samples, i.e. the width of the noise select vector.
- ROW_ADDR_WIDTH, 4, key-memory row address bits; must satisfy 2^ROW_ADDR_WIDTH > DIMENSION.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- job_valid  in  1  job offered
- job_ready  out  1  controller can accept a job
- job_plaintext  in  PLAINTEXT_WIDTH  plaintext of the offered job
- job_noise  in  BIG_N  noise/row-select vector of the offered job
- pk_rd_en  out  1  key-memory read strobe
- pk_addr  out  ROW_ADDR_WIDTH  key-memory row address
- enc_plaintext  out  PLAINTEXT_WIDTH  to datapath `plaintext`
- enc_noise_select  out  BIG_N  to datapath `noise_select`
- enc_row  out  DIMENSION+1  to datapath `row`
- enc_ciphertext  in  CIPHERTEXT_WIDTH  from datapath `ciphertext`
- ct_valid  out  1  ciphertext word available
- ct_ready  in  1  downstream accepts the word
- ct_data  out  CIPHERTEXT_WIDTH  ciphertext word
- ct_index  out  ROW_ADDR_WIDTH  row index of ct_data
- ct_last  out  1  ct_data is row DIMENSION
- busy  out  1  job in progress
- done  out  1  one-cycle pulse after the last word handshakes

Behaviour:
- Reset (async, rst_n=0) puts the block in IDLE and clears every register:
  - All outputs read 0 except job_ready, which is 1 (combinational from IDLE).
  - Reset mid-job abandons the job; no partial-job state survives.
- FSM states are IDLE, FETCH, COMPUTE, EMIT.
- IDLE:
  - job_ready=1.
  - On job_valid&job_ready, latch job_plaintext into plaintext_q and job_noise into noise_q, set row_q=0, go to FETCH.
- FETCH (1 cycle):
  - pk_rd_en=1, pk_addr=row_q.
  - Go to COMPUTE.
- COMPUTE (1 cycle):
  - Key memory has synchronous 1-cycle read latency, so its data feeds the datapath `publickey_row` in this cycle.
  - At the edge, capture enc_ciphertext into ct_data, set ct_index=row_q and ct_last=(row_q==DIMENSION), set ct_valid=1.
  - Go to EMIT.
- EMIT:
  - Hold ct_valid, ct_data, ct_index and ct_last stable until ct_ready=1.
  - On handshake, ct_valid falls next cycle.
  - If row_q==DIMENSION: pulse done for 1 cycle and go to IDLE.
  - Otherwise: row_q+1, go to FETCH.
- Datapath drive:
  - enc_row = row_q zero-extended to DIMENSION+1 bits.
  - enc_plaintext = plaintext_q and enc_noise_select = noise_q, constant for the whole job.
  - Plaintext injection at row 1 happens inside the datapath; the controller does not gate it.
- busy=1 in FETCH, COMPUTE and EMIT; 0 in IDLE.
- job_ready=0 while busy: one job in flight, and no job is accepted in the IDLE-return cycle.
  - After done, job_ready=1 in the following cycle.
- Latency with ct_ready held 1:
  - Job accept at edge E0; first ct_valid visible after edge E0+2.
  - Each row takes 3 cycles; a job occupies 3·(DIMENSION+1) cycles plus 1 IDLE cycle.
- Arithmetic: the ciphertext is taken verbatim from the datapath, i.e. the sum mod 2^CIPHERTEXT_WIDTH. The controller does no arithmetic except the row increment, which never wraps because it stops at DIMENSION.
- Backpressure: ct_ready low for any number of cycles stalls in EMIT. No new pk read is issued and all outputs are held.
- ct_ready asserted while ct_valid=0 is ignored.
- job_valid outside IDLE is ignored; the job source must hold the job until job_ready.

Test Plan:
- Reset/idle: assert rst_n=0 mid-EMIT at row 5 -> all outputs 0 immediately, job_ready=1 after release, next job starts at row 0.
- Basic job:
  - Stimulus: defaults, key memory row r = every sample equal to r+1, plaintext=5, noise=30'h1 (sample 0 only), ct_ready=1.
  - Response: 11 words with ct_index 0..10; ct_data[r]=r+1, except ct_data[1]=2+5=7; ct_last only on index 10; done 1 cycle after the last handshake; total 33 cycles.
- Modulo wrap:
  - Stimulus: all key samples = 1023, noise=all ones (30 samples), plaintext=0.
  - Response: each word = (30·1023) mod 1024 = 994; row 1 also 994.
- Backpressure:
  - Stimulus: ct_ready=0 for 7 cycles on row 3.
  - Response: ct_data, ct_index=3 and ct_valid held; pk_rd_en stays 0; row 4 fetch is issued the cycle after the handshake.
- Job handshake: job_valid held through the whole job with a second payload -> second job accepted exactly once, in the cycle after done, using the second payload's plaintext/noise.
- Zero noise: noise=0, plaintext=63 -> words all 0 except index 1 = 63.
